// File: rtl/bus_gen_arbiter_pkg.sv
// Shared types and helpers for the bus generator/arbiter.
// State enum, ID field constants, packet field accessors.
package bus_gen_arbiter_pkg;

   localparam int ID_W      = 8;
   localparam int PKT_MAX_W = 256;

   localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_POP  = 2'd1,
      S_PUSH = 2'd2
   } state_e;

   // Packets are passed zero-extended to PKT_MAX_W; sz is the real width.
   function automatic logic [ID_W-1:0] get_dest(
      input logic [PKT_MAX_W-1:0] pkt,
      input int                   sz
   );
      return pkt[sz-1 -: ID_W];
   endfunction

   function automatic logic [PKT_MAX_W-1:0] get_payload(
      input logic [PKT_MAX_W-1:0] pkt,
      input int                   sz
   );
      logic [PKT_MAX_W-1:0] m;
      m = (PKT_MAX_W'(1) << (sz - ID_W)) - PKT_MAX_W'(1);
      return pkt & m;
   endfunction

endpackage

// File: rtl/bus_gen_arbiter_rr.sv
// Combinational round-robin picker: first request above last_i.
// Ports: req_i, last_i in; grant_o (index), valid_o out.
module bus_gen_arbiter_rr #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] last_i,
   output logic [W-1:0] grant_o,
   output logic         valid_o
);

   int idx;

   // Scan N slots starting one past the last winner, wrapping mod N.
   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      idx     = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(last_i) + k) % N;
         if (!valid_o && req_i[idx]) begin
            valid_o = 1'b1;
            grant_o = W'(idx);
         end
      end
   end

endmodule

// File: rtl/bus_gen_arbiter.sv
// Shared-bus arbiter: grants one pending terminal (round-robin),
// pops its head packet and pushes it to the addressed terminal(s).
// Ports: clk, reset (async low), pndng/D_pop in; pop/push/D_push out.
module bus_gen_arbiter
   import bus_gen_arbiter_pkg::*;
#(
   parameter int              drvrs     = 4,
   parameter int              pckg_sz   = 16,
   parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [drvrs-1:0]                pndng,
   input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
   output logic [drvrs-1:0]                pop,
   output logic [drvrs-1:0]                push,
   output logic [pckg_sz-1:0]              D_push
);

   localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

   state_e               state_q;
   logic [PW-1:0]        src_q;
   logic [PW-1:0]        ptr_q;
   logic [drvrs-1:0]     pop_q;
   logic [drvrs-1:0]     push_q;
   logic [pckg_sz-1:0]   pkt_q;

   logic [PW-1:0]        grant;
   logic                 gnt_vld;
   logic [drvrs-1:0]     pop_d;
   logic [drvrs-1:0]     push_d;
   logic [pckg_sz-1:0]   head;
   logic [ID_W-1:0]      dest;
   logic                 is_bc;

   bus_gen_arbiter_rr #(
      .N (drvrs),
      .W (PW)
   ) u_rr (
      .req_i   (pndng),
      .last_i  (ptr_q),
      .grant_o (grant),
      .valid_o (gnt_vld)
   );

   assign head  = D_pop[src_q];
   assign dest  = get_dest(PKT_MAX_W'(head), pckg_sz);
   assign is_bc = (dest == broadcast);

   // Out-of-range IDs match no j, so invalid and self-addressed
   // packets produce an empty push mask and are dropped.
   always_comb begin
      pop_d  = '0;
      push_d = '0;
      for (int j = 0; j < drvrs; j++) begin
         pop_d[j] = (j == int'(grant));
         if (is_bc) begin
            push_d[j] = (j != int'(src_q));
         end else begin
            push_d[j] = (j == int'(dest)) && (j != int'(src_q));
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         ptr_q   <= PW'(drvrs - 1);
         pop_q   <= '0;
         push_q  <= '0;
         pkt_q   <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               push_q <= '0;
               pop_q  <= gnt_vld ? pop_d : '0;
               if (gnt_vld) begin
                  src_q   <= grant;
                  ptr_q   <= grant;
                  state_q <= S_POP;
               end
            end
            S_POP: begin
               pop_q   <= '0;
               pkt_q   <= head;
               push_q  <= push_d;
               state_q <= S_PUSH;
            end
            S_PUSH: begin
               push_q  <= '0;
               state_q <= S_IDLE;
            end
            default: begin
               pop_q   <= '0;
               push_q  <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign pop    = pop_q;
   assign push   = push_q;
   assign D_push = pkt_q;

endmodule

// File: tb/tb_bus_gen_arbiter.sv
// Self-checking bench for bus_gen_arbiter (4 terminals, 16-bit).
// Directed scenarios plus random traffic against a transfer model.
module tb_bus_gen_arbiter;

   logic              clk = 1'b0;
   logic              reset;
   logic [3:0]        pndng;
   logic [3:0][15:0]  dpop;
   logic [3:0]        pop;
   logic [3:0]        push;
   logic [15:0]       dpush;

   int n_chk = 0;
   int n_err = 0;

   // model: transfer progress, last winner, current source
   int          slot;
   int          last;
   int          src;
   logic [3:0]  e_pop;
   logic [3:0]  e_push;
   logic [15:0] e_dp;

   bit rec = 1'b0;
   int obs[$];
   int rr_exp[5] = '{0, 1, 2, 3, 0};

   logic [3:0][15:0] d;

   always #5 clk = ~clk;

   bus_gen_arbiter #(
      .drvrs     (4),
      .pckg_sz   (16),
      .broadcast (8'hFF)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .pndng  (pndng),
      .D_pop  (dpop),
      .pop    (pop),
      .push   (push),
      .D_push (dpush)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] dest_mask(input logic [15:0] p,
                                            input int s);
      int dst;
      dst = int'(p >> 8);
      if (dst == 255) return 4'hF & ~(4'(1) << s);
      if (dst < 4 && dst != s) return 4'(1) << dst;
      return 4'h0;
   endfunction

   task automatic model_reset();
      slot   = 0;
      last   = 3;
      src    = 0;
      e_pop  = '0;
      e_push = '0;
      e_dp   = '0;
   endtask

   // Drive inputs for the upcoming edge and predict the next cycle.
   task automatic apply(input logic [3:0] p, input logic [3:0][15:0] dd);
      int c;
      pndng = p;
      dpop  = dd;
      if (slot == 1) begin
         e_pop  = '0;
         e_dp   = dd[src];
         e_push = dest_mask(dd[src], src);
         slot   = 2;
      end else if (slot == 2) begin
         e_push = '0;
         slot   = 0;
      end else begin
         e_push = '0;
         e_pop  = '0;
         for (int k = 1; k <= 4; k++) begin
            c = (last + k) % 4;
            if (p[c] && slot == 0) begin
               src   = c;
               last  = c;
               e_pop = 4'(1) << c;
               slot  = 1;
            end
         end
      end
   endtask

   task automatic step(input logic [3:0] p, input logic [3:0][15:0] dd);
      @(negedge clk);
      check("pop", 32'(pop), 32'(e_pop));
      check("push", 32'(push), 32'(e_push));
      check("dpush", 32'(dpush), 32'(e_dp));
      if (rec && pop != 0) begin
         for (int i = 0; i < 4; i++) if (pop[i]) obs.push_back(i);
      end
      apply(p, dd);
   endtask

   task automatic xfer(input logic [3:0] p, input logic [3:0][15:0] dd);
      step(p, dd);
      step(4'h0, dd);
      step(4'h0, dd);
   endtask

   task automatic do_reset();
      @(negedge clk);
      pndng = 4'h0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   initial begin
      reset = 1'b0;
      pndng = 4'hF;
      for (int i = 0; i < 4; i++) d[i] = 16'h0133;
      dpop = d;
      model_reset();

      // reset held with all terminals pending
      repeat (3) begin
         @(negedge clk);
         check("rst_pop", 32'(pop), 32'h0);
         check("rst_push", 32'(push), 32'h0);
         check("rst_dpush", 32'(dpush), 32'h0);
      end
      reset = 1'b1;
      apply(4'hF, d);
      step(4'h0, d);
      step(4'h0, d);

      // unicast 0 -> 2
      d = '0;
      d[0] = 16'h02AB;
      xfer(4'b0001, d);

      // broadcast from 1
      d[1] = 16'hFF5A;
      xfer(4'b0010, d);

      // invalid ID, then self-addressed
      d[2] = 16'h0711;
      xfer(4'b0100, d);
      d[2] = 16'h0222;
      xfer(4'b0100, d);

      // fairness with everyone pending from a fresh pointer
      do_reset();
      for (int i = 0; i < 4; i++) d[i] = {8'((i + 1) % 4), 8'(i)};
      rec = 1'b1;
      repeat (15) step(4'hF, d);
      repeat (3) step(4'h0, d);
      rec = 1'b0;
      check("rr_count", 32'(obs.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < obs.size()) check("rr_order", 32'(obs[i]), 32'(rr_exp[i]));
      end

      // async reset while a push is on the bus
      do_reset();
      d = '0;
      d[0] = 16'h0133;
      step(4'b0001, d);
      step(4'h0, d);
      @(posedge clk);
      #2;
      check("pre_rst_push", 32'(push), 32'(e_push));
      reset = 1'b0;
      #1;
      check("arst_push", 32'(push), 32'h0);
      check("arst_pop", 32'(pop), 32'h0);
      check("arst_dpush", 32'(dpush), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      apply(4'hF, d);
      step(4'h0, d);
      step(4'h0, d);
      step(4'h0, d);

      // random traffic, including pending drops and data churn
      repeat (600) begin
         for (int i = 0; i < 4; i++) begin
            int sel;
            sel = $urandom_range(0, 5);
            d[i][7:0] = 8'($urandom);
            if (sel < 4)       d[i][15:8] = 8'(sel);
            else if (sel == 4) d[i][15:8] = 8'hFF;
            else               d[i][15:8] = 8'($urandom);
         end
         step(4'($urandom), d);
      end
      repeat (3) step(4'h0, d);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/bus_gen_arbiter.md
Name: bus_gen_arbiter

Overview:
Shared-bus generator and arbiter. It connects `drvrs` terminal FIFOs, one per driver/agent port, over a single bus. Each cycle-slot it grants one terminal with a pending packet using round-robin, pops that packet, and pushes it into the destination terminal(s) encoded in the packet header. It is the DUT below the Driver/Agente verification layer, and each terminal's in/out FIFO lives in the driver side.

Parameters:
- drvrs, 4, number of terminals (2..255).
- pckg_sz, 16, packet width in bits (>8); bits [pckg_sz-1:pckg_sz-8] are the destination ID, the rest is payload.
- broadcast, 8'hFF, destination ID meaning "all terminals except the source".

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- pndng  input  [drvrs-1:0]  terminal i has a packet at its FIFO head.
- D_pop  input  [drvrs-1:0][pckg_sz-1:0]  FIFO head data per terminal; valid while pndng[i]=1.
- pop  output  [drvrs-1:0]  one-cycle dequeue strobe to terminal i.
- push  output  [drvrs-1:0]  one-cycle enqueue strobe to terminal i.
- D_push  output  [pckg_sz-1:0]  packet driven to all terminals; qualified by push.

Behaviour:
- The clock is clk; reset is asynchronous and active-low.
- Reset (reset=0, async):
  - State=IDLE; pop=0, push=0, D_push=0.
  - Round-robin pointer=drvrs-1, so terminal 0 has first priority.
  - Reset mid-transfer abandons the packet: no push occurs, and a packet already popped is lost.
- All outputs are registered.
- FSM states: IDLE, POP, PUSH.
- IDLE:
  - If any pndng bit is 1, grant the first set bit searching upward from (pointer+1) mod drvrs.
  - Latch the grant index as src and set pointer=src.
  - Go to POP, with pop[src]=1 in the next cycle.
  - If no pndng bit is set, stay in IDLE.
- POP (one cycle):
  - pop[src]=1 and all other pop bits 0.
  - At the closing edge, capture D_pop[src] into the packet register; dest = packet[pckg_sz-1 -: 8].
  - Go to PUSH.
- PUSH (one cycle):
  - D_push = packet.
  - If dest==broadcast: push[j]=1 for all j≠src.
  - Else if dest<drvrs and dest≠src: push[dest]=1.
  - Else (invalid ID or self-addressed): packet dropped, push=0.
  - Go to IDLE.
- D_push holds its last value outside PUSH.
- Latency: pndng sampled high at edge n gives pop high during cycle n+1 and push high during cycle n+2. Throughput is one packet per 3 cycles.
- pndng changes during POP/PUSH are ignored until IDLE.
- pndng dropping between grant and pop does not abort the transfer: the pop is still issued and the bus carries whatever D_pop showed.
- Fairness: with all terminals pending continuously, grants cycle 0,1,2,…,drvrs-1,0. A terminal waits at most drvrs-1 other transfers.
- No backpressure: destination FIFOs are required to accept every push; overflow is the terminal's concern.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/POP/PUSH);
  - the BROADCAST_ID default;
  - the ID field width constant (8);
  - helper functions get_dest(packet) and get_payload(packet).
- One sub-module is natural: rr_arbiter, a round-robin priority picker.
  - Inputs: req[drvrs-1:0], last[$clog2(drvrs)-1:0].
  - Outputs: grant index, valid.
  - Purely combinational.

Test Plan (drvrs=4, pckg_sz=16):
1. Reset: hold reset=0 with pndng=4'hF → pop=0, push=0, D_push=0. After release, first pop is pop=4'b0001.
2. Unicast: pndng[0]=1, D_pop[0]=16'h02AB → pop=4'b0001 for one cycle, then push=4'b0100 with D_push=16'h02AB one cycle later. Terminals 1 and 3 are never pushed.
3. Broadcast: pndng[1]=1, D_pop[1]=16'hFF5A → push=4'b1101, D_push=16'hFF5A, for one cycle.
4. Round-robin: pndng=4'hF held, each D_pop[i]=16'h0(i+1 mod 4)_i → pop order 0,1,2,3,0, each followed by the correct single push bit.
5. Invalid/self: D_pop[2]=16'h0711, then D_pop[2]=16'h0222 → each popped once, push stays 0 for both.
6. Async reset during PUSH: assert reset=0 mid-cycle → push drops to 0 immediately, FSM returns to IDLE, and the next grant goes to terminal 0.
